// File: rtl/pc_fetch_unit_pkg.sv
// Shared constants and encodings for the PIC16C5x program-counter / fetch stage.
// The control unit's Q-state, execute-state and stack-command encodings live here.
package pc_fetch_unit_pkg;

    localparam int INST_WIDTH    = 12;
    localparam int PC_WIDTH_DEF  = 11;
    localparam int FE_STATE_BITS = 2;
    localparam int EX_STATE_BITS = 3;

    localparam logic [INST_WIDTH-1:0] I_NOP_12 = 12'h000;

    // Page-select field inside STATUS (PA1:PA0 = STATUS[6:5]).
    localparam int PA_LSB = 5;
    localparam int PA_MSB = 6;

    typedef enum logic [FE_STATE_BITS-1:0] {
        FE_Q1 = 2'd0,
        FE_Q2 = 2'd1,
        FE_Q3 = 2'd2,
        FE_Q4 = 2'd3
    } fe_state_e;

    typedef enum logic [EX_STATE_BITS-1:0] {
        EX_Q4_ELSE  = 3'd0,
        EX_Q4_GOTO  = 3'd1,
        EX_Q4_CALL  = 3'd2,
        EX_Q4_RETLW = 3'd3,
        EX_Q4_FSZ   = 3'd4,
        EX_Q4_BTFSX = 3'd5
    } ex_state_e;

    typedef enum logic [1:0] {
        STK_NOP  = 2'd0,
        STK_PUSH = 2'd1,
        STK_POP  = 2'd2
    } stk_cmd_e;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Bundle between the control unit / program ROM and the fetch stage.
// No valid/ready handshake: fetch_state == FE_Q4 is the sole qualifier, every other field is sampled only then.
interface pc_fetch_unit_if
    import pc_fetch_unit_pkg::*;
#(
    parameter int PC_WIDTH = PC_WIDTH_DEF
);
    logic [FE_STATE_BITS-1:0] fetch_state;
    logic [EX_STATE_BITS-1:0] exec_state;
    logic [1:0]               stack_cmd;
    logic [INST_WIDTH-1:0]    inst_in;
    logic [1:0]               pa_bits;
    logic                     skip_req;
    logic                     pcl_we;
    logic [7:0]               pcl_wdata;

    logic [PC_WIDTH-1:0]      rom_addr;
    logic [INST_WIDTH-1:0]    ir_out;
    logic [7:0]               pcl_out;
    logic [1:0]               stack_depth;
    // Stack contents exposed for observation.
    logic [PC_WIDTH-1:0]      stk0;
    logic [PC_WIDTH-1:0]      stk1;

    modport master (
        output fetch_state, exec_state, stack_cmd, inst_in, pa_bits,
               skip_req, pcl_we, pcl_wdata,
        input  rom_addr, ir_out, pcl_out, stack_depth, stk0, stk1
    );

    modport slave (
        input  fetch_state, exec_state, stack_cmd, inst_in, pa_bits,
               skip_req, pcl_we, pcl_wdata,
        output rom_addr, ir_out, pcl_out, stack_depth, stk0, stk1
    );

endinterface

// File: rtl/pc_fetch_unit_pic_stack.sv
// Two-entry hardware return stack with the PIC16C5x quirks: a pop leaves stk1 in place,
// a push when full drops the old stk1, and depth saturates at 0 and 2.
module pic_stack
    import pc_fetch_unit_pkg::*;
#(
    parameter int W = PC_WIDTH_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [1:0]   cmd,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] stk0,
    output logic [W-1:0] stk1,
    output logic [1:0]   depth
);

    logic [W-1:0] stk0_q, stk0_d;
    logic [W-1:0] stk1_q, stk1_d;
    logic [1:0]   depth_q, depth_d;

    always_comb begin
        stk0_d  = stk0_q;
        stk1_d  = stk1_q;
        depth_d = depth_q;
        if (en) begin
            if (cmd == STK_PUSH) begin
                stk1_d  = stk0_q;
                stk0_d  = push_data;
                depth_d = (depth_q == 2'd2) ? 2'd2 : depth_q + 2'd1;
            end else if (cmd == STK_POP) begin
                stk0_d  = stk1_q;
                depth_d = (depth_q == 2'd0) ? 2'd0 : depth_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stk0_q  <= '0;
            stk1_q  <= '0;
            depth_q <= 2'd0;
        end else begin
            stk0_q  <= stk0_d;
            stk1_q  <= stk1_d;
            depth_q <= depth_d;
        end
    end

    assign stk0  = stk0_q;
    assign stk1  = stk1_q;
    assign depth = depth_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// PIC16C5x program counter, instruction register and return stack.
// PC and IR change only on the edge that closes FE_Q4; jumps and skips flush IR to NOP.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int                  PC_WIDTH     = PC_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = {PC_WIDTH{1'b1}}
) (
    input  logic            clk,
    input  logic            rst_n,
    pc_fetch_unit_if.slave  bus
);

    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [INST_WIDTH-1:0] ir_q, ir_d;

    logic                  q4;
    logic [PC_WIDTH-1:0]   pc_inc;
    // Targets are formed at full 11-bit width; the page bits sit directly above
    // the 9-bit field, so keeping the low PC_WIDTH bits selects pa_bits[PC_WIDTH-10:0].
    logic [10:0]           goto_full;
    logic [10:0]           call_full;
    logic [10:0]           pcl_full;
    logic                  skip_state;

    logic [PC_WIDTH-1:0]   stk_top;
    logic [PC_WIDTH-1:0]   stk_next;
    logic [1:0]            stk_depth;

    assign q4         = (bus.fetch_state == FE_Q4);
    assign pc_inc     = pc_q + PC_WIDTH'(1);
    assign goto_full  = {bus.pa_bits, ir_q[8:0]};
    assign call_full  = {bus.pa_bits, 1'b0, ir_q[7:0]};
    assign pcl_full   = {bus.pa_bits, 1'b0, bus.pcl_wdata};
    assign skip_state = (bus.exec_state == EX_Q4_FSZ) || (bus.exec_state == EX_Q4_BTFSX);

    always_comb begin
        pc_d = pc_q;
        ir_d = ir_q;
        if (q4) begin
            if (bus.exec_state == EX_Q4_GOTO) begin
                pc_d = goto_full[PC_WIDTH-1:0];
                ir_d = I_NOP_12;
            end else if (bus.exec_state == EX_Q4_CALL) begin
                pc_d = call_full[PC_WIDTH-1:0];
                ir_d = I_NOP_12;
            end else if (bus.exec_state == EX_Q4_RETLW) begin
                pc_d = stk_top;
                ir_d = I_NOP_12;
            end else if (bus.pcl_we) begin
                pc_d = pcl_full[PC_WIDTH-1:0];
                ir_d = I_NOP_12;
            end else if (bus.skip_req && skip_state) begin
                pc_d = pc_inc;
                ir_d = I_NOP_12;
            end else begin
                pc_d = pc_inc;
                ir_d = bus.inst_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_VECTOR;
            ir_q <= I_NOP_12;
        end else begin
            pc_q <= pc_d;
            ir_q <= ir_d;
        end
    end

    // PC already points past the CALL when it executes, so it is the return address.
    pic_stack #(.W(PC_WIDTH)) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (q4),
        .cmd       (bus.stack_cmd),
        .push_data (pc_q),
        .stk0      (stk_top),
        .stk1      (stk_next),
        .depth     (stk_depth)
    );

    assign bus.rom_addr    = pc_q;
    assign bus.pcl_out     = pc_q[7:0];
    assign bus.ir_out      = ir_q;
    assign bus.stack_depth = stk_depth;
    assign bus.stk0        = stk_top;
    assign bus.stk1        = stk_next;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed program-flow scenarios followed by random Q-cycles,
// checked against an arithmetic model through an expected-value queue.
module tb_pc_fetch_unit;
    import pc_fetch_unit_pkg::*;

    localparam int W  = 11;
    localparam int EW = 8 + W + 12 + 2 + W + W;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pc_fetch_unit_if #(.PC_WIDTH(W)) bus ();

    pc_fetch_unit #(.PC_WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- reference model ----------------
    int m_pc, m_ir, m_depth;
    int m_stk[2];

    logic [EW-1:0] exp_q[$];
    string         tag_q[$];
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic model_reset();
        m_pc     = (1 << W) - 1;
        m_ir     = 0;
        m_depth  = 0;
        m_stk[0] = 0;
        m_stk[1] = 0;
    endtask

    task automatic model_q4(input int ex, input int cmd, input int inst, input int pa,
                            input int skip, input int we, input int wd);
        int modv;
        int old_pc;
        int top;
        modv   = 1 << W;
        old_pc = m_pc;
        top    = m_stk[0];
        if (ex == int'(EX_Q4_GOTO)) begin
            m_pc = (pa * 512 + m_ir % 512) % modv;
            m_ir = 0;
        end else if (ex == int'(EX_Q4_CALL)) begin
            m_pc = (pa * 512 + m_ir % 256) % modv;
            m_ir = 0;
        end else if (ex == int'(EX_Q4_RETLW)) begin
            m_pc = top;
            m_ir = 0;
        end else if (we != 0) begin
            m_pc = (pa * 512 + wd) % modv;
            m_ir = 0;
        end else begin
            m_pc = (old_pc + 1) % modv;
            if (skip != 0 && (ex == int'(EX_Q4_FSZ) || ex == int'(EX_Q4_BTFSX))) m_ir = 0;
            else m_ir = inst;
        end
        if (cmd == int'(STK_PUSH)) begin
            m_stk[1] = m_stk[0];
            m_stk[0] = old_pc;
            m_depth  = (m_depth < 2) ? m_depth + 1 : 2;
        end else if (cmd == int'(STK_POP)) begin
            m_stk[0] = m_stk[1];
            m_depth  = (m_depth > 0) ? m_depth - 1 : 0;
        end
    endtask

    function automatic logic [EW-1:0] model_word();
        return {8'(m_pc), W'(m_pc), 12'(m_ir), 2'(m_depth), W'(m_stk[0]), W'(m_stk[1])};
    endfunction

    task automatic push_exp(input string t);
        exp_q.push_back(model_word());
        tag_q.push_back(t);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [EW-1:0] act;
        logic [EW-1:0] e;
        string         t;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            t   = tag_q.pop_front();
            act = {bus.pcl_out, bus.rom_addr, bus.ir_out, bus.stack_depth, bus.stk0, bus.stk1};
            n_cmp++;
            if (act !== e) begin
                n_err++;
                $display("FAIL %s: got pcl=%h pc=%h ir=%h depth=%0d stk0=%h stk1=%h, expected pcl=%h pc=%h ir=%h depth=%0d stk0=%h stk1=%h",
                         t, act[EW-1 -: 8], act[EW-9 -: W], act[2*W+13 -: 12], act[2*W+1 -: 2],
                         act[2*W-1 -: W], act[W-1:0],
                         e[EW-1 -: 8], e[EW-9 -: W], e[2*W+13 -: 12], e[2*W+1 -: 2],
                         e[2*W-1 -: W], e[W-1:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic scramble_inputs();
        bus.exec_state = EX_STATE_BITS'($urandom_range(0, 7));
        bus.stack_cmd  = 2'($urandom_range(0, 3));
        bus.inst_in    = 12'($urandom);
        bus.pa_bits    = 2'($urandom);
        bus.skip_req   = 1'($urandom);
        bus.pcl_we     = 1'($urandom);
        bus.pcl_wdata  = 8'($urandom);
    endtask

    task automatic do_reset(input string t);
        rst_n = 1'b0;
        bus.fetch_state = FE_STATE_BITS'($urandom_range(0, 3));
        scramble_inputs();
        @(posedge clk);
        #1;
        model_reset();
        push_exp(t);
        rst_n = 1'b1;
    endtask

    // One full instruction cycle: junk on the control inputs during Q1-Q3, real values at Q4.
    task automatic inst_cycle(input logic [2:0] ex, input logic [1:0] cmd, input logic [11:0] inst,
                              input logic [1:0] pa, input logic skip, input logic we,
                              input logic [7:0] wd, input string t);
        for (int q = 0; q < 4; q++) begin
            bus.fetch_state = FE_STATE_BITS'(q);
            if (q < 3) begin
                scramble_inputs();
            end else begin
                bus.exec_state = ex;
                bus.stack_cmd  = cmd;
                bus.inst_in    = inst;
                bus.pa_bits    = pa;
                bus.skip_req   = skip;
                bus.pcl_we     = we;
                bus.pcl_wdata  = wd;
                model_q4(int'(ex), int'(cmd), int'(inst), int'(pa), int'(skip), int'(we), int'(wd));
            end
            @(posedge clk);
            #1;
            push_exp($sformatf("%s_q%0d", t, q + 1));
        end
    endtask

    task automatic fetch(input logic [11:0] inst, input string t);
        inst_cycle(EX_Q4_ELSE, STK_NOP, inst, 2'b00, 1'b0, 1'b0, 8'h00, t);
    endtask

    task automatic jump_to(input logic [10:0] addr, input string t);
        fetch(12'hA00 | {3'b000, addr[8:0]}, {t, "_fetch_goto"});
        inst_cycle(EX_Q4_GOTO, STK_NOP, 12'h000, addr[10:9], 1'b0, 1'b0, 8'h00, {t, "_goto"});
    endtask

    task automatic call_from(input logic [10:0] addr, input logic [7:0] tgt, input string t);
        jump_to(addr, t);
        fetch(12'h900 | {4'h0, tgt}, {t, "_fetch_call"});
        inst_cycle(EX_Q4_CALL, STK_PUSH, 12'h000, 2'b00, 1'b0, 1'b0, 8'h00, {t, "_call"});
    endtask

    task automatic retlw(input string t);
        fetch(12'h8AB, {t, "_fetch_retlw"});
        inst_cycle(EX_Q4_RETLW, STK_POP, 12'h000, 2'b00, 1'b0, 1'b0, 8'h00, {t, "_retlw"});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        bus.fetch_state = FE_Q1;
        scramble_inputs();
        model_reset();
        @(posedge clk);
        #1;
        do_reset("reset");

        // First cycle after reset: PC wraps from the reset vector to 0.
        fetch(12'h000, "first_cycle");

        // GOTO 0x1A5 on page 1; the word fetched alongside must not reach IR.
        fetch(12'hBA5, "fetch_goto");
        inst_cycle(EX_Q4_GOTO, STK_NOP, 12'hC12, 2'b01, 1'b0, 1'b0, 8'h00, "goto");
        fetch(12'hC12, "after_goto");

        // CALL 0x45 from 0x010 then RETLW.
        inst_cycle(EX_Q4_ELSE, STK_NOP, 12'h000, 2'b00, 1'b0, 1'b1, 8'h10, "pcl_to_010");
        fetch(12'h945, "fetch_call45");
        inst_cycle(EX_Q4_CALL, STK_PUSH, 12'h123, 2'b00, 1'b0, 1'b0, 8'h00, "call45");
        retlw("ret45");

        // Nested calls overflowing the two-entry stack, then three returns.
        call_from(11'h100, 8'h10, "c100");
        call_from(11'h200, 8'h20, "c200");
        call_from(11'h300, 8'h30, "c300");
        retlw("r1");
        retlw("r2");
        retlw("r3");
        retlw("r_empty");

        // Skips.
        jump_to(11'h020, "to020");
        fetch(12'h2C5, "fetch_decfsz");
        inst_cycle(EX_Q4_FSZ, STK_NOP, 12'h555, 2'b00, 1'b1, 1'b0, 8'h00, "fsz_skip");
        inst_cycle(EX_Q4_FSZ, STK_NOP, 12'h666, 2'b00, 1'b0, 1'b0, 8'h00, "fsz_noskip");
        inst_cycle(EX_Q4_ELSE, STK_NOP, 12'h777, 2'b00, 1'b1, 1'b0, 8'h00, "else_skip_ignored");
        inst_cycle(EX_Q4_BTFSX, STK_NOP, 12'h388, 2'b00, 1'b1, 1'b0, 8'h00, "btfsx_skip");

        // PCL writes, and a PCL write losing to GOTO.
        inst_cycle(EX_Q4_ELSE, STK_NOP, 12'h111, 2'b10, 1'b0, 1'b1, 8'h80, "pcl_write");
        fetch(12'hA33, "fetch_goto33");
        inst_cycle(EX_Q4_GOTO, STK_NOP, 12'h000, 2'b11, 1'b0, 1'b1, 8'h44, "goto_vs_pcl");

        // Stack commands with a non-matching execute state.
        inst_cycle(EX_Q4_ELSE, STK_PUSH, 12'h0F0, 2'b00, 1'b0, 1'b0, 8'h00, "push_else");
        inst_cycle(EX_Q4_FSZ, STK_POP, 12'h0F1, 2'b00, 1'b1, 1'b0, 8'h00, "pop_fsz");

        // Reset in the middle of an instruction cycle.
        bus.fetch_state = FE_Q2;
        do_reset("mid_reset");

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset("rand_reset");
            end else begin
                inst_cycle(EX_STATE_BITS'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                           12'($urandom), 2'($urandom), 1'($urandom),
                           1'($urandom_range(0, 7) == 0), 8'($urandom), "random");
            end
        end

        repeat (3) @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and fetch stage sitting directly upstream of the control unit.
- Holds the PC, the 2-level hardware return stack and the instruction register (IR).
- IR drives the control unit's instruction input; the control unit's fetch state, execute state and stack command steer PC/IR updates.
- Implements PIC16C5x GOTO/CALL/RETLW/PCL-write/skip semantics, including the pipeline flush (forced NOP) for two-cycle instructions.

Parameters:
- PC_WIDTH, 11, program counter width; legal values 9, 10 or 11.
- RESET_VECTOR, {PC_WIDTH{1'b1}}, PC value after reset (last ROM word).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- fetch_state  in  FE_STATE_BITS  current fetch Q-state
- exec_state  in  EX_STATE_BITS  current execute state
- stack_cmd  in  2  STK_NOP / STK_PUSH / STK_POP
- inst_in  in  INST_WIDTH  ROM data at rom_addr
- pa_bits  in  2  STATUS[6:5] page select
- skip_req  in  1  skip condition true (valid in EX_Q4_FSZ / EX_Q4_BTFSX)
- pcl_we  in  1  file-register write to PCL (0x02) this Q4
- pcl_wdata  in  8  data written to PCL
- rom_addr  out  PC_WIDTH  fetch address, equals PC
- ir_out  out  INST_WIDTH  instruction register, to the control unit
- pcl_out  out  8  PC[7:0], for reads of PCL
- stack_depth  out  2  valid stack entries, 0..2

Behaviour:
- Reset values:
  - PC = RESET_VECTOR, IR = 12'h000 (NOP).
  - Stack entries = 0, stack_depth = 0.
  - Outputs follow the registers.
- All state updates occur only on the clk edge ending a cycle with fetch_state == FE_Q4. In all other Q-states, registers hold.
- rom_addr and pcl_out are combinational from PC. ROM read latency is 0 (inst_in must be valid by FE_Q4).
- PC/IR update at FE_Q4, priority from highest to lowest:
  1. exec_state == EX_Q4_GOTO: PC <= {page, IR[8:0]}; IR <= NOP.
  2. exec_state == EX_Q4_CALL: PC <= {page, 1'b0, IR[7:0]}; IR <= NOP.
  3. exec_state == EX_Q4_RETLW: PC <= top of stack; IR <= NOP.
  4. pcl_we: PC <= {page, 1'b0, pcl_wdata}; IR <= NOP.
  5. skip_req with exec_state in {EX_Q4_FSZ, EX_Q4_BTFSX}: PC <= PC+1; IR <= NOP.
  6. Otherwise: PC <= PC+1; IR <= inst_in.
- Page and width rules:
  - page = pa_bits[PC_WIDTH-10:0] when PC_WIDTH > 9; empty when PC_WIDTH == 9.
  - PC+1 wraps modulo 2^PC_WIDTH (RESET_VECTOR+1 = 0).
- Ignored inputs:
  - skip_req outside EX_Q4_FSZ/EX_Q4_BTFSX.
  - pcl_we when GOTO/CALL/RETLW is active.
- Stack behaviour, driven by stack_cmd at FE_Q4 edges only:
  - PUSH: stk1 <= stk0; stk0 <= PC. The pushed PC is the current, already-incremented value, i.e. the return address = CALL address + 1.
  - POP: stk0 <= stk1; stk1 unchanged (silicon behaviour).
  - depth saturates at 2 on PUSH. A push when full silently discards the old stk1.
  - depth floors at 0 on POP. A pop when empty still returns stk0.
  - PUSH/POP with a non-matching exec_state: the stack is still updated; the PC source follows exec_state only.
- Reset asserted mid-instruction restores all reset values on the next edge, regardless of Q-state.

Decomposition:
- define.v additions:
  - PC_WIDTH default
  - RESET_VECTOR
  - I_NOP_12 constant
  - page-select field positions
- define.v constants reused: STK_*, FE_*, EX_*.
- One sub-module: pic_stack (2-entry register stack with push/pop/depth). The PC mux and IR stay in pc_fetch_unit.

Test Plan:
- Reset, then one full Q1–Q4 cycle -> rom_addr = 0x7FF during the cycle, 0x000 after FE_Q4; ir_out = 0x000 throughout; stack_depth = 0.
- IR = GOTO 0x1A5, pa_bits = 2'b01 -> PC = 0x3A5 after Q4; ir_out = NOP for the following cycle even though inst_in = 0xC12.
- CALL 0x45 at address 0x010, pa_bits = 0, stack_cmd = PUSH -> PC = 0x045, stk0 = 0x011, depth = 1. A following RETLW with POP -> PC = 0x011, depth = 0, IR flushed.
- Three nested CALLs from 0x100, 0x200, 0x300 -> depth = 2, stk0 = 0x301, stk1 = 0x201. Three RETLW -> PC = 0x301, then 0x201, then 0x201; depth 0.
- DECFSZ with skip_req = 1 at PC = 0x020 -> PC = 0x021, ir_out = NOP. The same instruction with skip_req = 0 -> ir_out = inst_in. skip_req = 1 during EX_Q4_ELSE -> no skip.
- pcl_we = 1, pcl_wdata = 0x80, pa_bits = 2'b10 -> PC = 0x480, IR = NOP, pcl_out = 0x80. pcl_we during GOTO -> GOTO target wins.
